// File: rtl/ga_pkg.sv
// Shared defaults, FSM state encoding and width helper for the GA evaluation sequencer.
package ga_pkg;

    localparam int GA_CHROMOSOME_LENGTH = 19;
    localparam int GA_CHAR_WIDTH        = 8;
    localparam int GA_FITNESS_WIDTH     = 5;
    localparam int GA_POP_SIZE          = 8;
    localparam int GA_TIMEOUT_CYCLES    = 64;

    // Sequencer states; IDLE is the only non-busy state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SEND   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RECORD = 3'd4,
        ST_DONE   = 3'd5
    } ga_state_t;

    // Index width for a table of n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ga_pop_mem.sv
// Population storage: POP_SIZE individuals of CHROMOSOME_LENGTH characters.
// Synchronous write with range gating, asynchronous read by individual/position.
// Contents are deliberately not reset so a population survives a reset.
module ga_pop_mem
    import ga_pkg::*;
#(
    parameter int CHROMOSOME_LENGTH = GA_CHROMOSOME_LENGTH,
    parameter int CHAR_WIDTH        = GA_CHAR_WIDTH,
    parameter int POP_SIZE          = GA_POP_SIZE
) (
    input  logic                                 clk,
    input  logic                                 we,
    input  logic [idx_w(POP_SIZE)-1:0]           wr_ind,
    input  logic [idx_w(CHROMOSOME_LENGTH)-1:0]  wr_pos,
    input  logic [CHAR_WIDTH-1:0]                wr_char,
    input  logic [idx_w(POP_SIZE)-1:0]           rd_ind,
    input  logic [idx_w(CHROMOSOME_LENGTH)-1:0]  rd_pos,
    output logic [CHAR_WIDTH-1:0]                rd_char
);

    logic [CHAR_WIDTH-1:0] mem [POP_SIZE][CHROMOSOME_LENGTH];
    logic                  in_range;

    // Indices that fall past the table are dropped rather than aliased.
    assign in_range = (int'(wr_ind) < POP_SIZE) && (int'(wr_pos) < CHROMOSOME_LENGTH);

    // Host write port.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[wr_ind][wr_pos] <= wr_char;
        end
    end

    assign rd_char = mem[rd_ind][rd_pos];

endmodule

// File: rtl/ga_eval_sequencer.sv
// Walks the stored population through an external fitness calculator one
// individual at a time, reports each fitness, and tracks the best so far.
//
// Handshake: the character stream has no backpressure. char_valid marks one
// character per cycle and the calculator must accept it; start_new_individual
// precedes each stream by one cycle. evaluation_done is a one-cycle valid for
// fitness_in and is only accepted while waiting for a result.
module ga_eval_sequencer
    import ga_pkg::*;
#(
    parameter int CHROMOSOME_LENGTH = GA_CHROMOSOME_LENGTH,
    parameter int CHAR_WIDTH        = GA_CHAR_WIDTH,
    parameter int FITNESS_WIDTH     = GA_FITNESS_WIDTH,
    parameter int POP_SIZE          = GA_POP_SIZE,
    parameter int TIMEOUT_CYCLES    = GA_TIMEOUT_CYCLES
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [idx_w(POP_SIZE)-1:0]           wr_ind,
    input  logic [idx_w(CHROMOSOME_LENGTH)-1:0]  wr_pos,
    input  logic [CHAR_WIDTH-1:0]                wr_char,
    input  logic                                 run_start,
    output logic                                 start_new_individual,
    output logic [CHAR_WIDTH-1:0]                char_out,
    output logic                                 char_valid,
    input  logic [FITNESS_WIDTH-1:0]             fitness_in,
    input  logic                                 evaluation_done,
    output logic                                 result_valid,
    output logic [idx_w(POP_SIZE)-1:0]           result_idx,
    output logic [FITNESS_WIDTH-1:0]             result_fitness,
    output logic [idx_w(POP_SIZE)-1:0]           best_idx,
    output logic [FITNESS_WIDTH-1:0]             best_fitness,
    output logic                                 perfect_found,
    output logic                                 timeout_err,
    output logic                                 busy,
    output logic                                 run_done
);

    localparam int IW = idx_w(POP_SIZE);
    localparam int PW = idx_w(CHROMOSOME_LENGTH);
    localparam int WW = idx_w(TIMEOUT_CYCLES);

    ga_state_t              state_q, state_d;
    logic [IW-1:0]          idx_q;
    logic [PW-1:0]          pos_q;
    logic [WW-1:0]          wait_q;
    logic [FITNESS_WIDTH-1:0] fit_q;
    logic [FITNESS_WIDTH-1:0] best_fit_q;
    logic [IW-1:0]          best_idx_q;
    logic                   perfect_q;
    logic                   timeout_q;
    logic [CHAR_WIDTH-1:0]  rd_char;
    logic                   last_pos;
    logic                   last_idx;
    logic                   wait_last;

    assign last_pos  = (pos_q == PW'(CHROMOSOME_LENGTH - 1));
    assign last_idx  = (idx_q == IW'(POP_SIZE - 1));
    assign wait_last = (wait_q == WW'(TIMEOUT_CYCLES - 1));

    // Host writes land only while no run is in progress.
    ga_pop_mem #(
        .CHROMOSOME_LENGTH (CHROMOSOME_LENGTH),
        .CHAR_WIDTH        (CHAR_WIDTH),
        .POP_SIZE          (POP_SIZE)
    ) u_pop_mem (
        .clk     (clk),
        .we      (wr_en && (state_q == ST_IDLE)),
        .wr_ind  (wr_ind),
        .wr_pos  (wr_pos),
        .wr_char (wr_char),
        .rd_ind  (idx_q),
        .rd_pos  (pos_q),
        .rd_char (rd_char)
    );

    // State register; reset abandons any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for one run over the population.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (run_start) state_d = ST_START;
            ST_START:  state_d = ST_SEND;
            ST_SEND:   if (last_pos) state_d = ST_WAIT;
            ST_WAIT: begin
                if (evaluation_done)  state_d = ST_RECORD;
                else if (wait_last)   state_d = ST_DONE;
            end
            ST_RECORD: begin
                if (fit_q == '0 || last_idx) state_d = ST_DONE;
                else                         state_d = ST_START;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counters, captured fitness and best-so-far tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            pos_q      <= '0;
            wait_q     <= '0;
            fit_q      <= '0;
            best_fit_q <= '0;
            best_idx_q <= '0;
            perfect_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_start) begin
                        idx_q      <= '0;
                        best_fit_q <= '1;
                        best_idx_q <= '0;
                        perfect_q  <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end
                ST_START: pos_q <= '0;
                ST_SEND: begin
                    pos_q  <= pos_q + 1'b1;
                    wait_q <= '0;
                end
                ST_WAIT: begin
                    wait_q <= wait_q + 1'b1;
                    if (evaluation_done) begin
                        fit_q <= fitness_in;
                    end else if (wait_last) begin
                        timeout_q <= 1'b1;
                    end
                end
                ST_RECORD: begin
                    // Strict compare so an equal score never displaces an earlier index.
                    if (fit_q < best_fit_q) begin
                        best_fit_q <= fit_q;
                        best_idx_q <= idx_q;
                    end
                    if (fit_q == '0) begin
                        perfect_q <= 1'b1;
                    end
                    if (state_d == ST_START) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        start_new_individual = (state_q == ST_START);
        char_valid           = (state_q == ST_SEND);
        char_out             = (state_q == ST_SEND) ? rd_char : '0;
        result_valid         = (state_q == ST_RECORD);
        result_idx           = (state_q == ST_RECORD) ? idx_q : '0;
        result_fitness       = (state_q == ST_RECORD) ? fit_q : '0;
        busy                 = (state_q != ST_IDLE);
        run_done             = (state_q == ST_DONE);
    end

    assign best_idx      = best_idx_q;
    assign best_fitness  = best_fit_q;
    assign perfect_found = perfect_q;
    assign timeout_err   = timeout_q;

endmodule

// File: doc/ga_eval_sequencer.md
GA_EVAL_SEQUENCER -- requirements
Module: ga_eval_sequencer

Interface
REQ-001 SHALL have parameter CHROMOSOME_LENGTH, default 19, characters per individual.
REQ-002 SHALL have parameter CHAR_WIDTH, default 8, bits per character.
REQ-003 SHALL have parameter FITNESS_WIDTH, default 5, fitness (mismatch count) width.
REQ-004 SHALL have parameter POP_SIZE, default 8, number of individuals stored.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum wait for evaluation_done.
REQ-006 SHALL have ports, in this order:
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  wr_en  in  1  host population write strobe
  wr_ind  in  clog2(POP_SIZE)  individual index of write
  wr_pos  in  clog2(CHROMOSOME_LENGTH)  character position of write
  wr_char  in  CHAR_WIDTH  character written
  run_start  in  1  one-cycle pulse; evaluate whole population
  start_new_individual  out  1  to fitness calculator, one-cycle pulse
  char_out  out  CHAR_WIDTH  serial character to calculator
  char_valid  out  1  char_out valid this cycle
  fitness_in  in  FITNESS_WIDTH  fitness from calculator
  evaluation_done  in  1  fitness_in valid this cycle
  result_valid  out  1  one-cycle pulse per evaluated individual
  result_idx  out  clog2(POP_SIZE)  index of that individual
  result_fitness  out  FITNESS_WIDTH  its fitness
  best_idx  out  clog2(POP_SIZE)  index of lowest fitness so far
  best_fitness  out  FITNESS_WIDTH  lowest fitness so far
  perfect_found  out  1  an individual scored 0 this run
  timeout_err  out  1  calculator failed to respond
  busy  out  1  run in progress
  run_done  out  1  one-cycle pulse at end of run

Function
REQ-007 SHALL store POP_SIZE x CHROMOSOME_LENGTH characters; wr_en writes wr_char at [wr_ind][wr_pos] on the clock edge, only when busy=0; writes while busy are ignored; out-of-range wr_pos/wr_ind are ignored.
REQ-008 SHALL implement states IDLE, START, SEND, WAIT, RECORD, DONE.
REQ-009 IDLE: run_start with busy=0 -> START; index=0, internal best_fitness set to all-ones, best_idx=0, perfect_found=0, timeout_err=0; run_start while busy is ignored.
REQ-010 START: start_new_individual=1 for exactly one cycle -> SEND.
REQ-011 SEND: char_valid=1 for exactly CHROMOSOME_LENGTH consecutive cycles beginning the cycle after START, char_out = stored character positions 0..CHROMOSOME_LENGTH-1 in order -> WAIT.
REQ-012 WAIT: on evaluation_done capture fitness_in -> RECORD; if TIMEOUT_CYCLES cycles elapse without it, set timeout_err=1 (sticky until next run_start) -> DONE.
REQ-013 RECORD: result_valid pulses one cycle with result_idx/result_fitness; best updated only if fitness < best_fitness (strict, ties keep lower index).
REQ-014 RECORD exit: fitness==0 sets perfect_found and -> DONE (early termination); else last index -> DONE; else index+1 -> START.
REQ-015 DONE: run_done=1 one cycle, busy=0 -> IDLE; busy=1 in all states except IDLE.
REQ-016 evaluation_done outside WAIT SHALL be ignored.
REQ-017 best_idx, best_fitness, perfect_found, timeout_err SHALL hold after DONE until next run_start.
REQ-018 With the standard calculator (evaluation_done 4 cycles after last char), per-individual period is 1+19+4+1 = 25 cycles.

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE and every output to 0, including mid-run; population storage is not cleared.
REQ-020 Deassertion mid-run SHALL NOT resume; a new run_start is required.

Structure
REQ-021 Shared package ga_pkg SHALL hold CHROMOSOME_LENGTH, CHAR_WIDTH, FITNESS_WIDTH, POP_SIZE defaults and the state encoding.
REQ-022 Population storage SHALL be one sub-module, ga_pop_mem (sync write, async read by index/position).

Verification
REQ-023 Write individual 0 = "I love GeeksforGeek", run_start with calculator attached -> one result_valid (idx 0, fitness 0), perfect_found=1, run_done, best_idx=0.
REQ-024 All 8 individuals 19x'X' except idx 5 with 3 mismatches -> 8 result_valid pulses, best_idx=5, best_fitness=3, perfect_found=0, run_done 200 cycles after run_start.
REQ-025 Idx 2 and idx 6 both 4 mismatches, others 19 -> best_idx=2, best_fitness=4.
REQ-026 evaluation_done tied low -> timeout_err=1 after 64 WAIT cycles, run_done pulse, result_valid never asserted.
REQ-027 wr_en while busy and run_start during SEND -> stored data and run sequence unchanged.
REQ-028 rst_n low during SEND of idx 3 -> all outputs 0 immediately, IDLE; next run_start restarts at idx 0.
